zbritesi_serial: RTL
====================

Name: zbritesi_serial

Overview:
- Bit-serial WIDTH-bit subtractor: computes D = A − B − BIN one bit per clock, LSB first, through a single full-subtractor cell and a borrow flop.
- Arithmetic counterpart of the 1-bit full adder cell; supplies the ALU's SUB/CMP path where area matters more than latency.
- Start/busy/done handshake toward the control unit; results held until the next accepted start.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  request; sampled only in IDLE or DONE.
- A  input  WIDTH  minuend; captured on the accepting edge.
- B  input  WIDTH  subtrahend; captured on the accepting edge.
- BIN  input  1  borrow-in; captured on the accepting edge.
- BUSY  output  1  high while bits are being processed.
- DONE  output  1  one-cycle pulse when results become valid.
- D  output  WIDTH  difference, valid from DONE until the next accepted START.
- BOUT  output  1  final borrow-out (1 = unsigned A < B+BIN).
- ZERO  output  1  D == 0, valid with D.

Behaviour:
- Reset (RST_N low, async): state IDLE; BUSY=0, DONE=0, D=0, BOUT=0, ZERO=0; counter=0; operand shift registers=0.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE → SHIFT on START=1: load A, B into shift registers; load borrow flop with BIN; clear counter; set BUSY=1.
  - SHIFT: each edge, the cell takes a=A_sr[0], b=B_sr[0], bw=borrow flop.
    - Computes d = a^b^bw and bw' = (~a&b)|(~a&bw)|(b&bw).
    - Shifts d into the MSB of the D register, shifting right.
    - Shifts A_sr and B_sr right; borrow flop ← bw'; counter increments.
  - SHIFT → DONE on the edge that processes bit WIDTH−1 (counter == WIDTH−1): BUSY←0, DONE←1, BOUT←bw', ZERO←(final D == 0).
  - DONE → IDLE on the next edge if START=0.
  - DONE → SHIFT on the next edge if START=1 (back-to-back op); DONE drops after exactly one cycle either way.
- Latency: START accepted at edge k; DONE high during the cycle following edge k+WIDTH; BUSY high for WIDTH cycles.
- START while in SHIFT is ignored; A, B and BIN are not re-sampled.
- D, BOUT and ZERO are undefined-in-progress during SHIFT: D holds partial shift contents. Consumers use them only at or after DONE.
- No arithmetic widening: D is mod 2^WIDTH; BOUT carries the unsigned underflow.
- Reset mid-SHIFT aborts immediately to reset values; no DONE is produced.
- Counter width is clog2(WIDTH); no wrap occurs because the transition happens at WIDTH−1.

Optional Feature:
- Macro ZBRITESI_SERIAL_OVF_EN.
- When defined: adds output port V (1 bit), the two's-complement overflow flag.
  - V = (A[W−1] ^ B[W−1]) & (A[W−1] ^ D[W−1]), registered with DONE.
  - Computed from captured sign bits, held in a 2-bit sign register.
  - Reset 0; held like D.
- When undefined: no V port and no sign registers; behaviour is otherwise identical.

Decomposition:
- Package zbritesi_pkg holds:
  - state typedef (IDLE, SHIFT, DONE, 2-bit encoding);
  - counter width function/constant CNT_W = clog2(WIDTH).
- One natural sub-module: zbritesi1bit, a combinational 1-bit full subtractor.
  - Ports A, B, BIN, D, BOUT.
  - Instantiated once inside the serial datapath.

Test Plan:
- Reset, then START with A=0x5A, B=0x3C, BIN=0 → DONE exactly 8 cycles after the accepting edge; D=0x1E, BOUT=0, ZERO=0.
- A=0x00, B=0x01, BIN=0 → D=0xFF, BOUT=1, ZERO=0; with OVF_EN, V=0.
- A=0x10, B=0x0F, BIN=1 → D=0x00, BOUT=0, ZERO=1.
- Signed overflow: A=0x80, B=0x01 → D=0x7F, BOUT=0, V=1 with the macro.
- Signed overflow: A=0x7F, B=0xFF → D=0x80, BOUT=1, V=1.
- Toggle START with new operands (0xFF, 0xFF) during SHIFT → ignored; the first operation's result is reported, with a single DONE pulse.
- START held high across DONE → second op (0x03 − 0x01) launches back-to-back; second DONE 8 cycles later with D=0x02.
- Assert RST_N low at bit 4 of an operation → BUSY, DONE, D, BOUT and ZERO are 0 immediately (async); no DONE after release; the next START completes normally.

Source files
------------

// File: rtl/zbritesi_pkg.sv
// Shared types for the bit-serial subtractor.
// Holds FSM state encoding and counter width helper.
`timescale 1ns/1ps
package zbritesi_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_SHIFT = 2'd1;
  localparam state_t S_DONE  = 2'd2;

  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/zbritesi1bit.sv
// Combinational 1-bit full subtractor cell.
// Ports: A, B, BIN in; D (difference), BOUT (borrow) out.
`timescale 1ns/1ps
module zbritesi1bit (
  input  logic A,
  input  logic B,
  input  logic BIN,
  output logic D,
  output logic BOUT
);

  assign D    = A ^ B ^ BIN;
  assign BOUT = (~A & B) | (~A & BIN) | (B & BIN);

endmodule

// File: rtl/zbritesi_serial.sv
// Bit-serial WIDTH-bit subtractor D = A - B - BIN, LSB first.
// Ports: CLK, RST_N, START, A, B, BIN in; BUSY, DONE, D, BOUT,
// ZERO out. Define ZBRITESI_SERIAL_OVF_EN to add overflow port V.
`timescale 1ns/1ps
module zbritesi_serial
  import zbritesi_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] D,
  output logic             BOUT,
  output logic             ZERO
`ifdef ZBRITESI_SERIAL_OVF_EN
  ,
  output logic             V
`endif
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             bw;
  logic [CNT_W-1:0] cnt;
  logic             cell_d;
  logic             cell_bout;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] d_next;

  zbritesi1bit u_cell (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .BIN  (bw),
    .D    (cell_d),
    .BOUT (cell_bout)
  );

  assign accept = START &&
                  (state == S_IDLE || state == S_DONE);
  assign last   = (state == S_SHIFT) &&
                  (cnt == CNT_W'(WIDTH - 1));
  assign d_next = {cell_d, D[WIDTH-1:1]};
  assign BUSY   = (state == S_SHIFT);
  assign DONE   = (state == S_DONE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: state <= START ? S_SHIFT : S_IDLE;
        S_SHIFT:        if (last) state <= S_DONE;
        default:        state <= S_IDLE;
      endcase
    end
  end

`ifdef ZBRITESI_SERIAL_OVF_EN
  // Captured sign bits {A msb, B msb}; D msb is the last cell output.
  logic [1:0] sign;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sign <= '0;
      V    <= 1'b0;
    end else if (accept) begin
      sign <= {A[WIDTH-1], B[WIDTH-1]};
    end else if (last) begin
      V <= (sign[1] ^ sign[0]) & (sign[1] ^ cell_d);
    end
  end
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_sr <= '0;
      b_sr <= '0;
      bw   <= 1'b0;
      cnt  <= '0;
      D    <= '0;
      BOUT <= 1'b0;
      ZERO <= 1'b0;
    end else if (accept) begin
      a_sr <= A;
      b_sr <= B;
      bw   <= BIN;
      cnt  <= '0;
    end else if (state == S_SHIFT) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      bw   <= cell_bout;
      D    <= d_next;
      if (last) begin
        BOUT <= cell_bout;
        ZERO <= (d_next == '0);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
